ssd_scan_ctrl: RTL and testbench

Time-multiplexing controller that shares one `ssd` hex-to-seven-segment decoder across `DIGITS` common-anode digits on the board display. It holds a double-buffered display word, updates it from a `load` pulse only at frame boundaries so digits never tear, and scans the digits at a fixed rate. A blanking guard before each digit suppresses ghosting. Optional leading-zero suppression is provided. It sits between the system datapath (the value producer) and the display pins.

---
 rtl/ssd_scan_ctrl_pkg.sv | 17 +
 rtl/ssd_scan_ctrl_if.sv | 32 +++
 rtl/ssd_scan_ctrl_ssd.sv | 30 +++
 rtl/ssd_scan_ctrl.sv | 152 +++++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ssd_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed seven-segment scan controller:
// blank segment pattern, scan FSM encoding and a small width helper.
package ssd_scan_ctrl_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // A one-digit display still needs a one-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ssd_scan_ctrl_if.sv
// Producer-side and display-side signals of the scan controller, bundled so the
// datapath (master) and the controller (slave) see one connection.
interface ssd_scan_ctrl_if #(
    parameter int DIGITS = 4
);

    logic                  load;
    logic [4*DIGITS-1:0]   data;
    logic                  lz_en;
    logic [6:0]            seg;
    logic [DIGITS-1:0]     an;
    logic                  pending;

    modport master (
        output load,
        output data,
        output lz_en,
        input  seg,
        input  an,
        input  pending
    );

    modport slave (
        input  load,
        input  data,
        input  lz_en,
        output seg,
        output an,
        output pending
    );

endinterface

// File: rtl/ssd_scan_ctrl_ssd.sv
// Hex nibble to seven-segment decoder, active-low segments in gfedcba order.
module ssd (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (hex)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller: double-buffered display word
// swapped only at frame boundaries, per-digit blanking guard, leading-zero blanking.
module ssd_scan_ctrl
    import ssd_scan_ctrl_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000,
    parameter int GUARD  = 500
) (
    input  logic           clk,
    input  logic           rst_n,
    ssd_scan_ctrl_if.slave bus
);

    localparam int W     = 4 * DIGITS;
    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = idx_width(DIGITS);

    localparam logic [CNT_W-1:0] CNT_GUARD_END = CNT_W'(GUARD - 1);
    localparam logic [CNT_W-1:0] CNT_SLOT_END  = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(DIGITS - 1);

    scan_state_t        state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [W-1:0]       stage_reg, stage_next;
    logic [W-1:0]       active_reg, active_next;
    logic               pending_reg, pending_next;
    logic [6:0]         seg_reg, seg_next;
    logic [DIGITS-1:0]  an_reg, an_next;

    logic [3:0]         nib [DIGITS];
    logic [DIGITS-1:0]  suppress;
    logic [3:0]         digit_nib;
    logic               digit_supp;
    logic [6:0]         dec_seg;
    logic               boundary;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
            assign nib[gi] = active_reg[4*gi +: 4];
        end
    endgenerate

    // A digit is blanked when it and every more significant digit are zero;
    // the rightmost digit always shows so a zero value still reads "0".
    always_comb begin
        logic zero_run;
        suppress = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_run    = zero_run && (nib[i] == 4'd0);
            suppress[i] = zero_run;
        end
    end

    always_comb begin
        digit_nib  = '0;
        digit_supp = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                digit_nib  = nib[i];
                digit_supp = suppress[i];
            end
        end
    end

    ssd u_ssd (
        .hex (digit_nib),
        .seg (dec_seg)
    );

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg + 1'b1;
        idx_next     = idx_reg;
        stage_next   = stage_reg;
        active_next  = active_reg;
        pending_next = pending_reg;
        seg_next     = SEG_BLANK;
        an_next      = '1;
        boundary     = 1'b0;

        case (state_reg)
            BLANK: begin
                if (cnt_reg == CNT_GUARD_END) begin
                    state_next = SHOW;
                end
            end
            SHOW: begin
                // A suppressed digit keeps its anode enabled; only segments go dark.
                an_next  = ~(DIGITS'(1) << idx_reg);
                seg_next = (bus.lz_en && digit_supp) ? SEG_BLANK : dec_seg;
                if (cnt_reg == CNT_SLOT_END) begin
                    state_next = BLANK;
                    cnt_next   = '0;
                    if (idx_reg == IDX_LAST) begin
                        idx_next = '0;
                        boundary = 1'b1;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = BLANK;
                cnt_next   = '0;
            end
        endcase

        if (boundary) begin
            if (pending_reg) begin
                active_next = stage_reg;
            end
            pending_next = 1'b0;
        end

        // A load coinciding with the boundary lands in stage after the old
        // stage has been promoted, so it stays pending for the next frame.
        if (bus.load) begin
            stage_next   = bus.data;
            pending_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= BLANK;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            stage_reg   <= '0;
            active_reg  <= '0;
            pending_reg <= 1'b0;
            seg_reg     <= SEG_BLANK;
            an_reg      <= '1;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            idx_reg     <= idx_next;
            stage_reg   <= stage_next;
            active_reg  <= active_next;
            pending_reg <= pending_next;
            seg_reg     <= seg_next;
            an_reg      <= an_next;
        end
    end

    assign bus.seg     = seg_reg;
    assign bus.an      = an_reg;
    assign bus.pending = pending_reg;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Self-checking bench for ssd_scan_ctrl: frame-arithmetic reference model driven
// by a log of load events, directed scenarios plus a randomized run.
module tb_ssd_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int DIV    = 8;
    localparam int GUARD  = 2;
    localparam int FRAME  = DIGITS * DIV;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    ssd_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

    ssd_scan_ctrl #(
        .DIGITS (DIGITS),
        .DIV    (DIV),
        .GUARD  (GUARD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int ph    = 0;              // clock edges since reset release
    int          ld_ph  [$];    // phase at which each load was sampled
    logic [15:0] ld_val [$];

    logic [6:0] hex_seg [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Word on display during phase p: the last load sampled strictly before
    // the boundary cycle that closed the previous frame.
    function automatic logic [15:0] exp_active(input int p);
        int fs = (p / FRAME) * FRAME;
        logic [15:0] v = 16'h0000;
        foreach (ld_ph[i]) if (ld_ph[i] < fs - 1) v = ld_val[i];
        return v;
    endfunction

    function automatic logic exp_pending(input int p);
        int b = ((p + 1) / FRAME) * FRAME - 1;
        if (b < 0) b = 0;
        foreach (ld_ph[i]) if (ld_ph[i] >= b && ld_ph[i] <= p) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] exp_an(input int p);
        int q = p % FRAME;
        logic [3:0] one = 4'b0001;
        if (q % DIV < GUARD) return 4'hF;
        return ~(one << (q / DIV));
    endfunction

    function automatic logic [6:0] exp_seg(input int p, input logic lz);
        int q = p % FRAME;
        int d = q / DIV;
        logic [15:0] upper = exp_active(p) >> (4 * d);
        if (q % DIV < GUARD) return 7'h7F;
        if (lz && d > 0 && upper == 16'h0000) return 7'h7F;
        return hex_seg[upper[3:0]];
    endfunction

    function automatic logic [11:0] exp_out(input int p, input logic lz);
        return {exp_seg(p, lz), exp_an(p), exp_pending(p)};
    endfunction

    function automatic int digit_of(input logic [3:0] an);
        for (int i = 0; i < DIGITS; i++) if (an[i] == 1'b0) return i;
        return -1;
    endfunction

    task automatic step(input logic ld, input logic [15:0] d);
        bus.load = ld;
        bus.data = ld ? d : 16'($urandom);
        @(posedge clk);
        if (ld) begin
            ld_ph.push_back(ph);
            ld_val.push_back(d);
        end
        ph++;
        #1;
        bus.load = 1'b0;
    endtask

    task automatic advance_to_frame();
        while (ph % FRAME != 0) step(1'b0, 16'h0000);
    endtask

    task automatic test_reset();
        logic [11:0] want;
        rst_n = 1'b0;
        bus.load = 1'b0;
        bus.data = '0;
        bus.lz_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({bus.seg, bus.an, bus.pending} !== {7'h7F, 4'hF, 1'b0})
            $display("FAIL reset_initial got=%h/%b/%b want=7f/1111/0", bus.seg, bus.an, bus.pending);
        rst_n = 1'b1;
        ph = 0;
        step(1'b1, 16'h9999);
        repeat (3) step(1'b0, 16'h0000);
        tests++;
        if (bus.an !== 4'b1110 || bus.pending !== 1'b1) begin
            fails++;
            $display("FAIL reset_preshow got an=%b pend=%b want an=1110 pend=1", bus.an, bus.pending);
        end
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if ({bus.seg, bus.an, bus.pending} !== {7'h7F, 4'hF, 1'b0}) begin
                fails++;
                $display("FAIL reset_midshow cyc=%0d got=%h/%b/%b want=7f/1111/0", i, bus.seg, bus.an, bus.pending);
            end
        end
        rst_n = 1'b1;
        ph = 0;
        ld_ph.delete();
        ld_val.delete();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'h0000);
            want = (i < 2) ? {7'h7F, 4'hF, 1'b0} : {7'h40, 4'b1110, 1'b0};
            tests++;
            if ({bus.seg, bus.an, bus.pending} !== want) begin
                fails++;
                $display("FAIL reset_release cyc=%0d got=%h want=%h", i + 1, {bus.seg, bus.an, bus.pending}, want);
            end
        end
    endtask

    task automatic test_scan();
        int low_cnt [DIGITS];
        int blank_cnt = 0;
        int first_rise [2];
        int rises = 0;
        logic [3:0] prev_an = 4'hF;
        logic [11:0] want;
        foreach (low_cnt[i]) low_cnt[i] = 0;
        advance_to_frame();
        step(1'b1, 16'h1234);
        advance_to_frame();
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b0, 16'h0000);
            want = exp_out(ph - 1, bus.lz_en);
            tests++;
            if ({bus.seg, bus.an, bus.pending} !== want) begin
                fails++;
                $display("FAIL scan ph=%0d got=%h want=%h", ph - 1, {bus.seg, bus.an, bus.pending}, want);
            end
            if (bus.an == 4'b1110 && prev_an == 4'hF && rises < 2) begin
                first_rise[rises] = ph;
                rises++;
            end
            prev_an = bus.an;
            if (i < FRAME) begin
                if (bus.an == 4'hF) blank_cnt++;
                else if (digit_of(bus.an) >= 0) low_cnt[digit_of(bus.an)]++;
            end
            if (bus.an == 4'b1110) begin
                tests++;
                if (bus.seg !== 7'h19) begin
                    fails++;
                    $display("FAIL scan_digit0 got seg=%h want=19", bus.seg);
                end
            end
            if (bus.an == 4'b1101) begin
                tests++;
                if (bus.seg !== 7'h30) begin
                    fails++;
                    $display("FAIL scan_digit1 got seg=%h want=30", bus.seg);
                end
            end
        end
        for (int d = 0; d < DIGITS; d++) begin
            tests++;
            if (low_cnt[d] != DIV - GUARD) begin
                fails++;
                $display("FAIL scan_slot digit=%0d got low cycles=%0d want=%0d", d, low_cnt[d], DIV - GUARD);
            end
        end
        tests++;
        if (blank_cnt != DIGITS * GUARD) begin
            fails++;
            $display("FAIL scan_blank got=%0d want=%0d", blank_cnt, DIGITS * GUARD);
        end
        tests++;
        if (rises != 2 || first_rise[1] - first_rise[0] != FRAME) begin
            fails++;
            $display("FAIL scan_frame_len got rises=%0d len=%0d want len=%0d", rises,
                     (rises == 2) ? first_rise[1] - first_rise[0] : -1, FRAME);
        end
    endtask

    task automatic test_tear_free();
        logic [11:0] want;
        logic ld;
        logic [15:0] d;
        advance_to_frame();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < FRAME; i++) begin
                ld = (f == 0 && i == 13) || (f == 1 && (i == 10 || i == 20));
                d  = (f == 1 && i == 20) ? 16'hBBBB : 16'hAAAA;
                step(ld, d);
                want = exp_out(ph - 1, bus.lz_en);
                tests++;
                if ({bus.seg, bus.an, bus.pending} !== want) begin
                    fails++;
                    $display("FAIL tear ph=%0d got=%h want=%h", ph - 1, {bus.seg, bus.an, bus.pending}, want);
                end
                if (f == 0 && i >= 13 && i < FRAME - 1) begin
                    tests++;
                    if (bus.pending !== 1'b1 || (bus.an != 4'hF && bus.seg === 7'h08)) begin
                        fails++;
                        $display("FAIL tear_old_frame i=%0d got pend=%b seg=%h want pend=1 old word", i, bus.pending, bus.seg);
                    end
                end
                if (f > 0 && bus.an != 4'hF) begin
                    tests++;
                    if (bus.seg !== ((f == 1) ? 7'h08 : 7'h03)) begin
                        fails++;
                        $display("FAIL tear_new_frame f=%0d got seg=%h want=%h", f, bus.seg, (f == 1) ? 7'h08 : 7'h03);
                    end
                end
                if (f == 1 && i < 10) begin
                    tests++;
                    if (bus.pending !== 1'b0) begin
                        fails++;
                        $display("FAIL tear_pending_clear i=%0d got=%b want=0", i, bus.pending);
                    end
                end
            end
        end
    endtask

    task automatic test_boundary_collision();
        logic [11:0] want;
        logic ld;
        advance_to_frame();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < FRAME; i++) begin
                ld = (f == 0) && (i == 0 || i == FRAME - 1);
                step(ld, (i == 0) ? 16'h5555 : 16'hFFFF);
                want = exp_out(ph - 1, bus.lz_en);
                tests++;
                if ({bus.seg, bus.an, bus.pending} !== want) begin
                    fails++;
                    $display("FAIL collide ph=%0d got=%h want=%h", ph - 1, {bus.seg, bus.an, bus.pending}, want);
                end
                if (f > 0 && bus.an != 4'hF) begin
                    tests++;
                    if (bus.seg !== ((f == 1) ? 7'h12 : 7'h0E)) begin
                        fails++;
                        $display("FAIL collide_seg f=%0d got=%h want=%h", f, bus.seg, (f == 1) ? 7'h12 : 7'h0E);
                    end
                end
                if (f == 1) begin
                    tests++;
                    if (bus.pending !== (i < FRAME - 1)) begin
                        fails++;
                        $display("FAIL collide_pending i=%0d got=%b want=%b", i, bus.pending, i < FRAME - 1);
                    end
                end
            end
        end
    endtask

    task automatic test_lz();
        logic [15:0] words [3] = '{16'h0005, 16'h0000, 16'h0100};
        logic [6:0] lz_want [3][4] = '{'{7'h12, 7'h7F, 7'h7F, 7'h7F},
                                       '{7'h40, 7'h7F, 7'h7F, 7'h7F},
                                       '{7'h40, 7'h40, 7'h79, 7'h7F}};
        logic [11:0] want;
        int d;
        int shown;
        bus.lz_en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            advance_to_frame();
            step(1'b1, words[c]);
            advance_to_frame();
            shown = 0;
            for (int i = 0; i < FRAME; i++) begin
                step(1'b0, 16'h0000);
                want = exp_out(ph - 1, bus.lz_en);
                tests++;
                if ({bus.seg, bus.an, bus.pending} !== want) begin
                    fails++;
                    $display("FAIL lz ph=%0d got=%h want=%h", ph - 1, {bus.seg, bus.an, bus.pending}, want);
                end
                d = digit_of(bus.an);
                if (d >= 0) begin
                    shown++;
                    tests++;
                    if (bus.seg !== lz_want[c][d]) begin
                        fails++;
                        $display("FAIL lz_digit word=%h digit=%0d got=%h want=%h", words[c], d, bus.seg, lz_want[c][d]);
                    end
                end
            end
            tests++;
            if (shown != DIGITS * (DIV - GUARD)) begin
                fails++;
                $display("FAIL lz_anode word=%h got enabled cycles=%0d want=%0d", words[c], shown, DIGITS * (DIV - GUARD));
            end
        end
        bus.lz_en = 1'b0;
    endtask

    task automatic test_random();
        logic [11:0] want;
        logic [3:0] prev_an = bus.an;
        for (int i = 0; i < 1200; i++) begin
            if (i % 50 == 0) bus.lz_en = 1'($urandom_range(0, 1));
            step(($urandom_range(0, 11) == 0), 16'($urandom));
            want = exp_out(ph - 1, bus.lz_en);
            tests++;
            if ({bus.seg, bus.an, bus.pending} !== want) begin
                fails++;
                $display("FAIL random ph=%0d got=%h want=%h", ph - 1, {bus.seg, bus.an, bus.pending}, want);
            end
            tests++;
            if ($countones(~bus.an) > 1 || (prev_an != 4'hF && bus.an != 4'hF && bus.an != prev_an)) begin
                fails++;
                $display("FAIL random_anode ph=%0d got prev=%b now=%b want one-hot-low via 1111", ph - 1, prev_an, bus.an);
            end
            prev_an = bus.an;
        end
        bus.lz_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_tear_free();
        test_boundary_collision();
        test_lz();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
